// File: rtl/demux_1to4_buffered_if.sv
// Stream bundle for the buffered 1-to-4 demux: one valid/ready input beat and four registered output channels.
interface demux_1to4_buffered_if #(
  parameter int DATAWIDTH = 32
);
  logic [DATAWIDTH-1:0] in_data;
  logic [1:0]           in_select;
  logic                 in_valid;
  logic                 in_ready;
  logic [DATAWIDTH-1:0] outA_data;
  logic [DATAWIDTH-1:0] outB_data;
  logic [DATAWIDTH-1:0] outC_data;
  logic [DATAWIDTH-1:0] outD_data;
  logic [3:0]           out_valid;
  logic [3:0]           out_ready;
  logic [15:0]          stall_count;

  modport slave (
    input  in_data, in_select, in_valid, out_ready,
    output in_ready, outA_data, outB_data, outC_data, outD_data, out_valid, stall_count
  );

  modport master (
    output in_data, in_select, in_valid, out_ready,
    input  in_ready, outA_data, outB_data, outC_data, outD_data, out_valid, stall_count
  );
endinterface

// File: rtl/demux_1to4_buffered.sv
// Registered 1-to-4 demux with a 1-entry slot per channel so one stalled consumer never blocks the others.
// Optional input-stall counter enabled by defining DEMUX_STALL_CNT_EN.
module demux_1to4_buffered #(
  parameter int DATAWIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  demux_1to4_buffered_if.slave   bus
);

  logic [3:0]           r_valid;
  logic [DATAWIDTH-1:0] r_data [4];
  logic [3:0]           w_sel_oh;
  logic                 w_in_ready;
  logic [3:0]           w_load;
  logic [3:0]           w_drain;

  // Ready depends only on the selected slot, so out_ready may reach in_ready combinationally.
  assign w_sel_oh   = 4'b0001 << bus.in_select;
  assign w_in_ready = ~r_valid[bus.in_select] | bus.out_ready[bus.in_select];
  assign w_load     = {4{bus.in_valid & w_in_ready}} & w_sel_oh;
  assign w_drain    = r_valid & bus.out_ready;

  for (genvar g = 0; g < 4; g++) begin : g_slot
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_valid[g] <= 1'b0;
        r_data[g]  <= '0;
      end else if (w_load[g]) begin
        r_valid[g] <= 1'b1;
        r_data[g]  <= bus.in_data;
      end else if (w_drain[g]) begin
        r_valid[g] <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_valid;
  assign bus.outA_data = r_data[0];
  assign bus.outB_data = r_data[1];
  assign bus.outC_data = r_data[2];
  assign bus.outD_data = r_data[3];

`ifdef DEMUX_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // Saturating count of cycles where a beat is offered but refused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 16'h0000;
    end else if (bus.in_valid && !w_in_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign bus.stall_count = r_stall_cnt;
`else
  assign bus.stall_count = 16'h0000;
`endif

endmodule
